seg_ser_rx: RTL and testbench
=============================

Name: seg_ser_rx

Overview:
- Receiver end of the four-wire serial display link (SEGCLK, SEGCLR, SEGDT, SEGEN) that the score display transmitter drives.
- Deserialises one 64-bit segment frame, checks its length, and presents the frame in parallel in the clk domain.
- Used as a loopback monitor and display mirror, e.g. for on-board self-test and for comparing the shown score against game state.

Parameters:
- FRAME_BITS, 64, bits per frame; must be ≥ 24 and ≤ 64.
- SYNC_STAGES, 2, synchroniser flops per input line; must be ≥ 2.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- SEGCLK  in  1  serial bit clock; data is sampled on its rising edge.
- SEGCLR  in  1  active-low frame clear / start.
- SEGDT  in  1  serial data, MSB (bit FRAME_BITS-1) first.
- SEGEN  in  1  rising edge marks end of frame (latch).
- frame  out  FRAME_BITS  last accepted frame.
- frame_valid  out  1  one-cycle pulse when frame updates.
- len_err  out  1  one-cycle pulse when a frame is rejected for wrong bit count.
- busy  out  1  high while in SHIFT.
- digits  out  12  decoded hex digits from frame[23:0] (optional feature).
- glyph_err  out  1  at least one of frame[23:0] bytes is not a valid hex glyph (optional feature).
- hdr_ok  out  1  frame[63:24] equals the SCORE header (optional feature).

Behaviour:
- Reset (rst=0, async): frame=0, frame_valid=0, len_err=0, busy=0, digits=0, glyph_err=0, hdr_ok=0, FSM=IDLE, shift register=0, bit_cnt=0.
- Input conditioning:
  - All four inputs pass through SYNC_STAGES flops.
  - One further register per line provides edge detection on the synchronised signals.
  - SEGCLK high and low phases are each ≥ SYNC_STAGES+1 clk periods; behaviour outside that is unspecified.
  - SEGDT must be stable across the SEGCLK rising edge ±1 clk.
- FSM states: IDLE and SHIFT.
  - IDLE: synchronised SEGCLR low → clear shift register, bit_cnt=0, go to SHIFT. SEGCLK and SEGEN edges are ignored in IDLE.
  - SHIFT, SEGCLK rising edge: shreg <= {shreg[FRAME_BITS-2:0], SEGDT_sync}; bit_cnt increments and saturates at FRAME_BITS+1.
  - SHIFT, SEGEN rising edge with bit_cnt == FRAME_BITS: frame <= shreg, frame_valid pulses for one cycle, go to IDLE.
  - SHIFT, SEGEN rising edge with any other bit_cnt: frame is unchanged, len_err pulses for one cycle, go to IDLE.
  - SHIFT, synchronised SEGCLR low: restart the frame (clear shreg and bit_cnt, stay in SHIFT). This takes priority over a same-cycle SEGCLK or SEGEN edge.
  - A SEGCLK rise and a SEGEN rise detected in the same cycle: shift first, then evaluate the count including that bit.
- Latency: frame_valid or len_err asserts SYNC_STAGES+1 clk cycles after SEGEN rises at the pin.
- busy = (state == SHIFT).
- Back-to-back frames need no gap beyond the SEGCLR pulse.
- Reset asserted mid-frame aborts the frame; no pulse is produced.

Optional Feature:
- Macro: SEG_RX_DECODE_EN.
- Defined:
  - digits, glyph_err and hdr_ok are registered and update in the same cycle as frame.
  - frame[23:0] holds three active-low 7-segment bytes, most significant digit in the high byte. Each byte maps to a 4-bit hex value via the inverse glyph table; 0xC0 decodes to 0.
  - An unknown byte decodes to 0 and sets glyph_err.
  - hdr_ok = (frame[63:24] == 40'h92C6C08886).
  - Requires FRAME_BITS == 64.
- Not defined: the three ports exist but are tied to 0, and no decode logic is built.

Decomposition:
- Package seg_rx_pkg: 16-entry active-low hex glyph table, SCORE header constant (40'h92C6C08886), FSM state enum {IDLE, SHIFT}.
- One natural sub-module: seg_glyph_decode, combinational, byte in → {valid, nibble} out. It is instantiated three times under SEG_RX_DECODE_EN.

Test Plan:
- Frame 64'h92C6C08886_A4F9C0 sent MSB first with legal timing → frame_valid pulse exactly SYNC_STAGES+1 cycles after SEGEN rises; frame = that value. With decode enabled: digits = 12'h210, hdr_ok=1, glyph_err=0.
- Frame of only 63 SEGCLK pulses, then SEGEN → len_err pulse, frame keeps its previous value, FSM returns to IDLE. Repeat with 66 pulses → len_err.
- SEGCLR pulsed low after 30 bits, then a full 64-bit frame 64'h0123456789ABCDEF → a single frame_valid with that value; no len_err.
- SEGEN rise and SEGCLK pulses while in IDLE (no SEGCLR) → no output pulses, busy stays 0.
- rst driven low after 40 bits, released, then a full frame → no pulse before the release; the following frame is received correctly.
- With decode enabled, frame[7:0] = 8'hFF → glyph_err=1, digits[3:0]=0.

Source files
------------

// File: rtl/seg_ser_rx_pkg.sv
// Shared types and constants for the segment-link receiver: FSM states,
// the SCORE header and the active-low hex glyph table.
package seg_rx_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } rx_state_e;

   localparam logic [39:0] SCORE_HDR = 40'h92C6C08886;

   // Entry n is the active-low 7-segment byte shown for hex digit n (bit 7 = dp, unlit).
   localparam logic [15:0][7:0] GLYPH_TAB = {
      8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
      8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
   };

endpackage

// File: rtl/seg_ser_rx_if.sv
// Four-wire serial display link: the transmitter is master, the receiver slave.
interface seg_ser_rx_if;
   logic SEGCLK;
   logic SEGCLR;
   logic SEGDT;
   logic SEGEN;

   modport master (output SEGCLK, SEGCLR, SEGDT, SEGEN);
   modport slave  (input  SEGCLK, SEGCLR, SEGDT, SEGEN);
endinterface

// File: rtl/seg_ser_rx_glyph_decode.sv
// Inverse glyph lookup: active-low 7-segment byte to hex nibble, with a
// valid flag that is low for bytes outside the table (nibble then reads 0).
module seg_glyph_decode
   import seg_rx_pkg::*;
(
   input  logic [7:0] seg_byte,
   output logic       valid,
   output logic [3:0] nibble
);

   always_comb begin
      valid  = 1'b0;
      nibble = 4'h0;
      for (int i = 0; i < 16; i++) begin
         if (seg_byte == GLYPH_TAB[i]) begin
            valid  = 1'b1;
            nibble = 4'(i);
         end
      end
   end

endmodule

// File: rtl/seg_ser_rx.sv
// Segment-link receiver: synchronises the four link wires, deserialises one
// frame MSB first and checks its length. Optional glyph decode: SEG_RX_DECODE_EN.
//
// state | meaning
// IDLE  | waiting for SEGCLR low; SEGCLK / SEGEN edges ignored
// SHIFT | collecting bits on SEGCLK rises until SEGEN rises
module seg_ser_rx
   import seg_rx_pkg::*;
#(
   parameter int FRAME_BITS  = 64,
   parameter int SYNC_STAGES = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   seg_ser_rx_if.slave           seg,
   output logic [FRAME_BITS-1:0] frame,
   output logic                  frame_valid,
   output logic                  len_err,
   output logic                  busy,
   output logic [11:0]           digits,
   output logic                  glyph_err,
   output logic                  hdr_ok
);

   localparam int              CNT_W    = $clog2(FRAME_BITS + 2);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(FRAME_BITS + 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
   // Line order {SEGEN, SEGDT, SEGCLR, SEGCLK}; SEGCLR idles high so it must reset high.
   localparam logic [3:0]      LINE_RST = 4'b0010;

   logic [3:0]                   pins;
   logic [SYNC_STAGES-1:0][3:0]  sync_q;
   logic [3:0]                   lines;
   logic [1:0]                   edge_q;
   logic                         clk_rise;
   logic                         en_rise;
   logic                         clr_low;
   logic                         dt;

   rx_state_e                    state;
   logic [FRAME_BITS-1:0]        shreg;
   logic [FRAME_BITS-1:0]        shreg_nx;
   logic [CNT_W-1:0]             bit_cnt;
   logic [CNT_W-1:0]             cnt_nx;

   assign pins = {seg.SEGEN, seg.SEGDT, seg.SEGCLR, seg.SEGCLK};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_q <= {SYNC_STAGES{LINE_RST}};
         edge_q <= 2'b00;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], pins};
         edge_q <= {lines[3], lines[0]};
      end
   end

   assign lines    = sync_q[SYNC_STAGES-1];
   assign clk_rise = lines[0] & ~edge_q[0];
   assign en_rise  = lines[3] & ~edge_q[1];
   assign clr_low  = ~lines[1];
   assign dt       = lines[2];

   // Shift happens ahead of the length check so a same-cycle SEGEN counts this bit.
   always_comb begin
      shreg_nx = shreg;
      cnt_nx   = bit_cnt;
      if (clk_rise) begin
         shreg_nx = {shreg[FRAME_BITS-2:0], dt};
         if (bit_cnt != CNT_MAX) cnt_nx = bit_cnt + 1'b1;
      end
   end

`ifdef SEG_RX_DECODE_EN
   logic [2:0]  dec_valid;
   logic [11:0] dec_digits;

   for (genvar g = 0; g < 3; g++) begin : g_dec
      seg_glyph_decode u_dec (
         .seg_byte (shreg_nx[8*g +: 8]),
         .valid    (dec_valid[g]),
         .nibble   (dec_digits[4*g +: 4])
      );
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         digits    <= '0;
         glyph_err <= 1'b0;
         hdr_ok    <= 1'b0;
      end else if (state == SHIFT && !clr_low && en_rise && cnt_nx == CNT_FULL) begin
         digits    <= dec_digits;
         glyph_err <= ~&dec_valid;
         hdr_ok    <= (shreg_nx[63:24] == SCORE_HDR);
      end
   end
`else
   assign digits    = '0;
   assign glyph_err = 1'b0;
   assign hdr_ok    = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         shreg       <= '0;
         bit_cnt     <= '0;
         frame       <= '0;
         frame_valid <= 1'b0;
         len_err     <= 1'b0;
         busy        <= 1'b0;
      end else begin
         frame_valid <= 1'b0;
         len_err     <= 1'b0;
         case (state)
            IDLE: begin
               if (clr_low) begin
                  shreg   <= '0;
                  bit_cnt <= '0;
                  state   <= SHIFT;
                  busy    <= 1'b1;
               end
            end
            SHIFT: begin
               if (clr_low) begin
                  shreg   <= '0;
                  bit_cnt <= '0;
               end else if (en_rise) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  if (cnt_nx == CNT_FULL) begin
                     frame       <= shreg_nx;
                     frame_valid <= 1'b1;
                  end else begin
                     len_err <= 1'b1;
                  end
               end else begin
                  shreg   <= shreg_nx;
                  bit_cnt <= cnt_nx;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seg_ser_rx.sv
// Bench for seg_ser_rx: random and directed frames on the serial link against
// a transaction-level model of what each frame must produce and when.
module tb_seg_ser_rx;

   localparam int FB   = 64;
   localparam int SYNC = 2;
   localparam int HALF = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic [FB-1:0] frame;
   logic        frame_valid, len_err, busy, glyph_err, hdr_ok;
   logic [11:0] digits;

   seg_ser_rx_if sif ();

   seg_ser_rx #(.FRAME_BITS(FB), .SYNC_STAGES(SYNC)) dut (
      .clk         (clk),
      .rst         (rst),
      .seg         (sif.slave),
      .frame       (frame),
      .frame_valid (frame_valid),
      .len_err     (len_err),
      .busy        (busy),
      .digits      (digits),
      .glyph_err   (glyph_err),
      .hdr_ok      (hdr_ok)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Transaction-level model: link state as seen at the pins plus one pending result.
   bit            m_rx = 0;
   int            m_cnt = 0;
   logic [FB-1:0] m_val = '0;
   bit            pend_active = 0;
   bit            pend_ok;
   int            pend_cyc;
   logic [FB-1:0] pend_frame;
   logic [FB-1:0] exp_frame = '0;
   logic [11:0]   exp_dig = '0;
   bit            exp_gerr = 0, exp_hdr = 0;
   int            fv_count = 0, le_count = 0;
   int            last_fv_cyc = 0, en_cyc = 0;

   localparam bit [7:0] GLYPH [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                       8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

   function automatic logic [3:0] glyph_nib(input logic [7:0] b, output bit ok);
      ok = 0;
      glyph_nib = 4'h0;
      for (int i = 0; i < 16; i++)
         if (GLYPH[i] == b) begin ok = 1; glyph_nib = 4'(i); end
   endfunction

   always @(negedge clk) begin
      bit exp_fv, exp_le;
      exp_fv = 0;
      exp_le = 0;
      if (pend_active && cyc == pend_cyc) begin
         pend_active = 0;
         if (pend_ok) begin
            bit ok2, ok1, ok0;
            exp_fv    = 1;
            exp_frame = pend_frame;
            exp_dig   = {glyph_nib(pend_frame[23:16], ok2), glyph_nib(pend_frame[15:8], ok1),
                         glyph_nib(pend_frame[7:0], ok0)};
            exp_gerr  = !(ok2 && ok1 && ok0);
            exp_hdr   = (pend_frame[63:24] == 40'h92C6C08886);
         end else begin
            exp_le = 1;
         end
      end
      chk("frame_valid", 64'(frame_valid), 64'(exp_fv));
      chk("len_err", 64'(len_err), 64'(exp_le));
      chk("frame", frame, exp_frame);
`ifdef SEG_RX_DECODE_EN
      chk("digits", 64'(digits), 64'(exp_dig));
      chk("glyph_err", 64'(glyph_err), 64'(exp_gerr));
      chk("hdr_ok", 64'(hdr_ok), 64'(exp_hdr));
`else
      chk("decode_off", {51'd0, digits, glyph_err}, 64'(hdr_ok));
`endif
      if (frame_valid) begin fv_count++; last_fv_cyc = cyc; end
      if (len_err) le_count++;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_bit(input logic b);
      sif.SEGDT = b;
      tick(HALF);
      sif.SEGCLK = 1'b1;
      if (m_rx) begin
         m_val = {m_val[FB-2:0], b};
         m_cnt++;
      end
      tick(HALF);
      sif.SEGCLK = 1'b0;
   endtask

   task automatic clr_pulse();
      sif.SEGCLR = 1'b0;
      m_rx  = 1;
      m_cnt = 0;
      m_val = '0;
      tick(HALF);
      chk("busy_after_clr", 64'(busy), 64'd1);
      sif.SEGCLR = 1'b1;
      tick(HALF);
   endtask

   task automatic en_pulse();
      tick(2);
      sif.SEGEN = 1'b1;
      en_cyc = cyc;
      if (m_rx) begin
         pend_active = 1;
         pend_cyc    = cyc + SYNC + 1;
         pend_ok     = (m_cnt == FB);
         pend_frame  = m_val;
         m_rx        = 0;
      end
      tick(HALF);
      sif.SEGEN = 1'b0;
      tick(HALF);
      chk("busy_after_en", 64'(busy), 64'd0);
   endtask

   task automatic send_frame(input logic [63:0] d, input int n);
      clr_pulse();
      for (int i = n - 1; i >= 0; i--)
         send_bit(i < 64 ? d[i] : 1'($urandom));
      en_pulse();
   endtask

   task automatic do_reset(input int hold);
      rst = 1'b0;
      m_rx = 0;
      pend_active = 0;
      exp_frame = '0;
      exp_dig = '0;
      exp_gerr = 0;
      exp_hdr = 0;
      tick(hold);
      rst = 1'b1;
      tick(2);
   endtask

   initial begin
      int fv0, le0;
      logic [63:0] rnd;
      sif.SEGCLK = 1'b0;
      sif.SEGCLR = 1'b1;
      sif.SEGDT  = 1'b0;
      sif.SEGEN  = 1'b0;
      do_reset(5);
      chk("reset_busy", 64'(busy), 64'd0);
      chk("reset_frame", frame, 64'd0);

      // Reference frame: SCORE header with digits 2,1,0
      fv0 = fv_count;
      send_frame(64'h92C6C08886_A4F9C0, FB);
      chk("ref_frame", frame, 64'h92C6C08886_A4F9C0);
      chk("ref_fv_count", 64'(fv_count - fv0), 64'd1);
      chk("ref_latency", 64'(last_fv_cyc - en_cyc), 64'(SYNC + 1));
`ifdef SEG_RX_DECODE_EN
      chk("ref_digits", 64'(digits), 64'h210);
      chk("ref_hdr_ok", 64'(hdr_ok), 64'd1);
      chk("ref_glyph_err", 64'(glyph_err), 64'd0);
`endif

      // Short and long frames are rejected
      le0 = le_count;
      send_frame(64'h1234_5678_9ABC_DEF0, FB - 1);
      chk("short_len_err", 64'(le_count - le0), 64'd1);
      chk("short_frame_kept", frame, 64'h92C6C08886_A4F9C0);
      send_frame(64'hFFFF_0000_FFFF_0000, FB + 2);
      chk("long_len_err", 64'(le_count - le0), 64'd2);
      chk("long_frame_kept", frame, 64'h92C6C08886_A4F9C0);

      // Restart after 30 bits, then a full frame
      fv0 = fv_count; le0 = le_count;
      clr_pulse();
      for (int i = 0; i < 30; i++) send_bit(1'($urandom));
      send_frame(64'h0123456789ABCDEF, FB);
      chk("restart_fv", 64'(fv_count - fv0), 64'd1);
      chk("restart_le", 64'(le_count - le0), 64'd0);
      chk("restart_frame", frame, 64'h0123456789ABCDEF);

      // Edges while idle are ignored
      fv0 = fv_count; le0 = le_count;
      for (int i = 0; i < 5; i++) send_bit(1'($urandom));
      chk("idle_busy", 64'(busy), 64'd0);
      en_pulse();
      tick(8);
      chk("idle_no_pulse", 64'(fv_count - fv0 + le_count - le0), 64'd0);

      // Reset mid-frame, then a good frame
      fv0 = fv_count; le0 = le_count;
      clr_pulse();
      for (int i = 0; i < 40; i++) send_bit(1'($urandom));
      do_reset(6);
      chk("rst_no_pulse", 64'(fv_count - fv0 + le_count - le0), 64'd0);
      chk("rst_frame_clear", frame, 64'd0);
      send_frame(64'hDEAD_BEEF_CAFE_F00D, FB);
      chk("post_rst_frame", frame, 64'hDEAD_BEEF_CAFE_F00D);
      chk("post_rst_fv", 64'(fv_count - fv0), 64'd1);

`ifdef SEG_RX_DECODE_EN
      send_frame(64'h92C6C08886_A4F9FF, FB);
      chk("bad_glyph_err", 64'(glyph_err), 64'd1);
      chk("bad_glyph_nib", 64'(digits[3:0]), 64'd0);
      chk("bad_glyph_hi", 64'(digits[11:4]), 64'h21);
`endif

      // Random frames, lengths and mid-frame restarts
      for (int k = 0; k < 24; k++) begin
         int n;
         rnd = {$urandom, $urandom};
         if ($urandom_range(0, 3) == 0)
            rnd = {40'h92C6C08886, GLYPH[$urandom_range(0, 15)], GLYPH[$urandom_range(0, 15)],
                   GLYPH[$urandom_range(0, 15)]};
         n = ($urandom_range(0, 2) != 0) ? FB : $urandom_range(24, FB + 4);
         if ($urandom_range(0, 4) == 0) begin
            clr_pulse();
            for (int i = 0; i < $urandom_range(1, 20); i++) send_bit(1'($urandom));
         end
         send_frame(rnd, n);
      end

      tick(10);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
